// File: rtl/mem_crc_pkg.sv
// Shared constants for the CRC-protected memory controller: one-hot state
// encoding, default CRC parameters and request direction codes.
package mem_crc_pkg;

    localparam int unsigned ST_W     = 8;
    localparam int unsigned S_IDLE   = 0;
    localparam int unsigned S_CRCW   = 1;
    localparam int unsigned S_WRITE  = 2;
    localparam int unsigned S_RDISS  = 3;
    localparam int unsigned S_RDWAIT = 4;
    localparam int unsigned S_CRCR   = 5;
    localparam int unsigned S_CHECK  = 6;
    localparam int unsigned S_RESP   = 7;

    typedef enum logic [ST_W-1:0] {
        IDLE   = ST_W'(1) << S_IDLE,
        CRCW   = ST_W'(1) << S_CRCW,
        WRITE  = ST_W'(1) << S_WRITE,
        RDISS  = ST_W'(1) << S_RDISS,
        RDWAIT = ST_W'(1) << S_RDWAIT,
        CRCR   = ST_W'(1) << S_CRCR,
        CHECK  = ST_W'(1) << S_CHECK,
        RESP   = ST_W'(1) << S_RESP
    } state_e;

    localparam int unsigned CRC_W_DEF    = 4;
    localparam logic [3:0]  CRC_POLY_DEF = 4'h3;
    localparam logic [3:0]  CRC_INIT_DEF = 4'h0;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/crc_serial.sv
// Bit-serial MSB-first CRC register; init reseeds, en folds in one data bit.
module crc_serial
    import mem_crc_pkg::*;
#(
    parameter int unsigned      CRC_W    = CRC_W_DEF,
    parameter logic [CRC_W-1:0] CRC_POLY = CRC_POLY_DEF,
    parameter logic [CRC_W-1:0] CRC_INIT = CRC_INIT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             en,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_q, crc_d;
    logic             fb;

    always_comb begin
        fb    = crc_q[CRC_W-1] ^ din;
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/mem_crc_ctrl.sv
// Single-outstanding memory controller: writes store {data, crc}; reads
// recheck the stored CRC and retry up to MAX_RETRY times before flagging.
module mem_crc_ctrl
    import mem_crc_pkg::*;
#(
    parameter int unsigned      DATA_W    = 8,
    parameter int unsigned      ADDR_W    = 4,
    parameter int unsigned      CRC_W     = CRC_W_DEF,
    parameter logic [CRC_W-1:0] CRC_POLY  = CRC_POLY_DEF,
    parameter logic [CRC_W-1:0] CRC_INIT  = CRC_INIT_DEF,
    parameter int unsigned      MEM_LAT   = 1,
    parameter int unsigned      MAX_RETRY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_rw,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W+CRC_W-1:0] mem_wdata,
    input  logic [DATA_W+CRC_W-1:0] mem_rdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic [2:0]              rsp_retries,
    output logic [7:0]              state
);

    localparam int unsigned WORD_W = DATA_W + CRC_W;
    localparam int unsigned BIT_W  = $clog2(DATA_W);
    localparam int unsigned LAT_W  = $clog2(MEM_LAT + 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [2:0]          retry_q, retry_d;
    logic                req_ready_q, req_ready_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                crc_init, crc_en, crc_din;
    logic [CRC_W-1:0]    crc;
    logic [DATA_W-1:0]   crc_src, crc_shift;
    logic                bit_last, lat_last;

    crc_serial #(
        .CRC_W   (CRC_W),
        .CRC_POLY(CRC_POLY),
        .CRC_INIT(CRC_INIT)
    ) u_crc (
        .clk  (clk),
        .reset(reset),
        .init (crc_init),
        .en   (crc_en),
        .din  (crc_din),
        .crc  (crc)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        bit_cnt_d   = bit_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        retry_d     = retry_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        crc_init    = 1'b0;
        crc_en      = 1'b0;
        bit_last    = (bit_cnt_q == BIT_W'(DATA_W - 1));
        lat_last    = (lat_cnt_q == LAT_W'(MEM_LAT - 1));
        // One engine serves both passes; the source word follows the state.
        crc_src     = (state_q == CRCR) ? rdata_q[WORD_W-1:CRC_W] : wdata_q;
        crc_shift   = crc_src << bit_cnt_q;
        crc_din     = crc_shift[DATA_W-1];

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    bit_cnt_d = '0;
                    if (req_rw == RW_WRITE) begin
                        state_d  = CRCW;
                        crc_init = 1'b1;
                    end else begin
                        state_d = RDISS;
                    end
                end
            end
            CRCW: begin
                crc_en    = 1'b1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_last) begin
                    bit_cnt_d = '0;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
                state_d     = RESP;
            end
            RDISS: begin
                lat_cnt_d = '0;
                state_d   = RDWAIT;
            end
            RDWAIT: begin
                lat_cnt_d = lat_cnt_q + 1'b1;
                if (lat_last) begin
                    rdata_d   = mem_rdata;
                    bit_cnt_d = '0;
                    crc_init  = 1'b1;
                    state_d   = CRCR;
                end
            end
            CRCR: begin
                crc_en    = 1'b1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_last) begin
                    bit_cnt_d = '0;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                rsp_rdata_d = rdata_q[WORD_W-1:CRC_W];
                if (crc == rdata_q[CRC_W-1:0]) begin
                    rsp_err_d = 1'b0;
                    state_d   = RESP;
                end else if (retry_q < 3'(MAX_RETRY)) begin
                    retry_d = retry_q + 1'b1;
                    state_d = RDISS;
                end else begin
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    retry_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        mem_en_d    = (state_d == WRITE) || (state_d == RDISS);
        mem_we_d    = (state_d == WRITE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            bit_cnt_q   <= '0;
            lat_cnt_q   <= '0;
            retry_q     <= '0;
            req_ready_q <= 1'b1;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            bit_cnt_q   <= bit_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            retry_q     <= retry_d;
            req_ready_q <= req_ready_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // The CRC settles on the edge that enters WRITE, so the word is gated, not latched.
    assign mem_wdata   = mem_we_q ? {wdata_q, crc} : '0;
    assign req_ready   = req_ready_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = addr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_retries = retry_q;
    assign state       = state_q;

endmodule

// File: tb/tb_mem_crc_ctrl.sv
// Scoreboard bench for mem_crc_ctrl: two instances (MEM_LAT 1 and 3) share a
// behavioural memory that can corrupt the CRC field of chosen read accesses.
module tb_mem_crc_ctrl;
    import mem_crc_pkg::*;

    localparam int DW = 8, AW = 4, CW = 4, WW = DW + CW, MAXR = 2;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
        logic [2:0]    retries;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid[2], req_ready[2], req_rw[2], rsp_ready[2];
    logic          mem_en[2], mem_we[2], rsp_valid[2], rsp_err[2];
    logic [AW-1:0] req_addr[2], mem_addr[2];
    logic [DW-1:0] req_wdata[2], rsp_rdata[2];
    logic [WW-1:0] mem_wdata[2], mem_rdata[2];
    logic [2:0]    rsp_retries[2];
    logic [7:0]    state[2];

    logic [WW-1:0] mem_arr[2][16];
    logic [WW-1:0] pipe[2][3];
    int unsigned   acc_no[2], bad_n[2];
    logic [DW-1:0] shadow[2][16];
    logic [WW-1:0] last_wword;
    rsp_t          sb_q[$];
    int            n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_crc_ctrl #(
            .DATA_W   (DW),
            .ADDR_W   (AW),
            .CRC_W    (CW),
            .CRC_POLY (4'h3),
            .CRC_INIT (4'h0),
            .MEM_LAT  ((g == 0) ? 1 : 3),
            .MAX_RETRY(MAXR)
        ) u_dut (
            .clk        (clk),
            .reset      (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_rw     (req_rw[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .mem_en     (mem_en[g]),
            .mem_we     (mem_we[g]),
            .mem_addr   (mem_addr[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_rdata  (mem_rdata[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_rdata  (rsp_rdata[g]),
            .rsp_err    (rsp_err[g]),
            .rsp_retries(rsp_retries[g]),
            .state      (state[g])
        );
    end

    // Synchronous memory; read data is zero outside its valid slot.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_en[i] && mem_we[i]) mem_arr[i][mem_addr[i]] <= mem_wdata[i];
            pipe[i][0] <= (mem_en[i] && !mem_we[i]) ?
                          (mem_arr[i][mem_addr[i]] ^ ((acc_no[i] <= bad_n[i]) ? WW'(1) : WW'(0))) : '0;
            pipe[i][1] <= pipe[i][0];
            pipe[i][2] <= pipe[i][1];
        end
    end

    always_comb begin
        mem_rdata[0] = pipe[0][0];
        mem_rdata[1] = pipe[1][2];
    end

    function automatic logic [CW-1:0] crc_ref(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        c = 4'h0;
        for (int b = DW - 1; b >= 0; b--) begin
            if (c[CW-1] ^ d[b]) c = (c << 1) ^ 4'h3;
            else                c = c << 1;
        end
        return c;
    endfunction

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_vec++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
        end
    endtask

    task automatic run_txn(input int i, input logic rw, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input int unsigned nbad,
                           input int hold, input bit keep_valid);
        rsp_t        e, got;
        int unsigned lat, r, exp_lat, pulses, first_en, cyc, addr_bad, we_bad, wd_bad, stab_bad;
        bit          seen;
        lat      = (i == 0) ? 1 : 3;
        r        = (rw == RW_READ) ? ((nbad > MAXR) ? MAXR : nbad) : 0;
        e.rdata  = (rw == RW_READ) ? shadow[i][addr] : '0;
        e.err    = (rw == RW_READ) && (nbad > MAXR);
        e.retries = 3'(r);
        exp_lat  = (rw == RW_READ) ? DW + lat + 3 + r * (DW + lat + 2) : DW + 2;
        pulses = 0; first_en = 0; addr_bad = 0; we_bad = 0; wd_bad = 0; stab_bad = 0; seen = 0;
        bad_n[i]     = nbad;
        acc_no[i]    = 0;
        req_valid[i] = 1'b1;
        req_rw[i]    = rw;
        req_addr[i]  = addr;
        req_wdata[i] = wd;
        cyc = 0;
        while (!req_ready[i] && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!req_ready[i]) begin
            expect_eq("accept_timeout", 32'(req_ready[i]), 32'd1);
            req_valid[i] = 1'b0;
            return;
        end
        sb_q.push_back(e);
        if (rw == RW_WRITE) shadow[i][addr] = wd;
        @(negedge clk);
        cyc = 1;
        if (!keep_valid) req_valid[i] = 1'b0;
        while (cyc < 400) begin
            if (mem_en[i]) begin
                pulses++;
                acc_no[i] = pulses;
                if (first_en == 0) first_en = cyc;
                if (mem_we[i] !== ~rw) we_bad++;
                if (rw == RW_WRITE) begin
                    last_wword = mem_wdata[i];
                    if (mem_wdata[i] !== {wd, crc_ref(wd)}) wd_bad++;
                end
            end
            if (mem_addr[i] !== addr) addr_bad++;
            if (rsp_valid[i]) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        expect_eq("rsp_seen", 32'(seen), 32'd1);
        expect_eq("latency", cyc, exp_lat);
        expect_eq("mem_en_pulses", pulses, r + 1);
        expect_eq("mem_we", we_bad, 0);
        expect_eq("mem_addr_stable", addr_bad, 0);
        if (rw == RW_WRITE) begin
            expect_eq("write_pulse_cycle", first_en, DW + 1);
            expect_eq("mem_wdata", wd_bad, 0);
        end
        for (int h = 0; h < hold; h++) begin
            if (rsp_valid[i] !== 1'b1 || {rsp_rdata[i], rsp_err[i], rsp_retries[i]} !== e ||
                req_ready[i] !== 1'b0 || mem_en[i] !== 1'b0 || mem_addr[i] !== addr) stab_bad++;
            @(negedge clk);
        end
        if (hold > 0) expect_eq("rsp_stable", stab_bad, 0);
        rsp_ready[i] = 1'b1;
        got = {rsp_rdata[i], rsp_err[i], rsp_retries[i]};
        if (sb_q.size() == 0) begin
            expect_eq("sb_empty", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            expect_eq("rsp_rdata", 32'(got.rdata), 32'(e.rdata));
            expect_eq("rsp_err", 32'(got.err), 32'(e.err));
            expect_eq("rsp_retries", 32'(got.retries), 32'(e.retries));
        end
        @(negedge clk);
        rsp_ready[i] = 1'b0;
        expect_eq("rsp_valid_drop", 32'(rsp_valid[i]), 32'd0);
        if (keep_valid) begin
            expect_eq("ready_after_hs", 32'(req_ready[i]), 32'd1);
            req_valid[i] = 1'b0;
        end
    endtask

    initial begin
        int cyc;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        rst = 1'b1;
        last_wword = '0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_rw[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
            rsp_ready[i] = 1'b0; acc_no[i] = 0; bad_n[i] = 0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            expect_eq("rst_state", 32'(state[i]), 32'h01);
            expect_eq("rst_ready", 32'(req_ready[i]), 32'd1);
            expect_eq("rst_outputs", 32'({mem_en[i], mem_we[i], rsp_valid[i], rsp_err[i], rsp_retries[i]}), 32'd0);
            expect_eq("rst_buses", 32'({mem_addr[i], mem_wdata[i], rsp_rdata[i]}), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        run_txn(0, RW_WRITE, 4'h3, 8'hA5, 0, 0, 0);
        expect_eq("wword_A5", 32'(last_wword), 32'hA5B);
        run_txn(0, RW_READ, 4'h3, 8'h00, 0, 0, 0);
        run_txn(0, RW_READ, 4'h3, 8'h00, 7, 0, 0);
        run_txn(0, RW_READ, 4'h3, 8'h00, 1, 0, 0);
        run_txn(0, RW_READ, 4'h3, 8'h00, 0, 5, 1);
        run_txn(0, RW_WRITE, 4'h9, 8'h3C, 0, 2, 1);

        // Abort a read while its CRC pass is running.
        req_valid[0] = 1'b1; req_rw[0] = RW_READ; req_addr[0] = 4'h3;
        @(negedge clk);
        req_valid[0] = 1'b0;
        cyc = 0;
        while (state[0] !== 8'h20 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        expect_eq("reach_crcr", 32'(state[0]), 32'h20);
        rst = 1'b1;
        #1;
        expect_eq("abort_state", 32'(state[0]), 32'h01);
        expect_eq("abort_mem_en", 32'(mem_en[0]), 32'd0);
        expect_eq("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_txn(0, RW_READ, 4'h3, 8'h00, 0, 0, 0);

        run_txn(1, RW_WRITE, 4'h5, 8'hA5, 0, 0, 0);
        run_txn(1, RW_READ, 4'h5, 8'h00, 0, 3, 1);
        run_txn(1, RW_READ, 4'h5, 8'h00, 2, 0, 0);
        run_txn(1, RW_READ, 4'h5, 8'h00, 3, 0, 0);

        for (int k = 0; k < 4; k++) begin
            ra = AW'($urandom_range(0, 15));
            rd = DW'($urandom);
            run_txn(0, RW_WRITE, ra, rd, 0, 0, 0);
            run_txn(0, RW_READ, ra, 8'h00, $urandom_range(0, 3), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
